// File: rtl/noc_pkg.sv
// Shared NoC definitions: single-flit packet layout, node ID type, injector FSM
// encoding and the random-destination helper used by traffic sources.
package noc_pkg;
    localparam int DEST_HI = 31;
    localparam int DEST_LO = 26;
    localparam int PID_HI  = 15;
    localparam int PID_LO  = 6;
    localparam int SRC_HI  = 5;
    localparam int SRC_LO  = 0;

    typedef logic [5:0] node_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_GAP
    } inj_state_e;

    // bits = {lfsr[4:3], lfsr[1:0]}; mask = dim-1. Self-hits are pushed to the next column.
    function automatic node_id_t rand_dest(input logic [3:0] bits, input node_id_t self,
                                           input logic [2:0] mask);
        logic [2:0] x;
        logic [2:0] y;
        x = {1'b0, bits[1:0]} & mask;
        y = {1'b0, bits[3:2]} & mask;
        if ({x, y} == self) x = (x + 3'd1) & mask;
        return {x, y};
    endfunction
endpackage

// File: rtl/packet_injector_if.sv
// Local-port Req/Gnt/Full handshake between a traffic source and its router.
interface packet_injector_if #(
    parameter int dataWidth = 32
);
    logic [dataWidth-1:0] PacketOut;
    logic                 ReqDnStr;
    logic                 GntDnStr;
    logic                 DnStrFull;

    modport master (output PacketOut, output ReqDnStr, input GntDnStr, input DnStrFull);
    modport slave  (input PacketOut, input ReqDnStr, output GntDnStr, output DnStrFull);
endinterface

// File: rtl/noc_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting; seed reloads on reset.
module noc_lfsr16 #(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_adv,
    output logic [15:0] o_state
);
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= Seed;
        else if (i_adv)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign o_state = r_lfsr;
endmodule

// File: rtl/packet_injector.sv
// PE-side traffic source: forms single-flit packets and pushes them into the
// router local port, one every InjectGap+2 idle cycles at best.
module packet_injector
    import noc_pkg::*;
#(
    parameter logic [5:0]  ModuleID    = 6'b000_000,
    parameter int          dataWidth   = 32,
    parameter int          dim         = 4,
    parameter logic [5:0]  DestID      = 6'b000_000,
    parameter int          TrafficMode = 0,
    parameter int          InjectGap   = 4,
    parameter int          NumPackets  = 16,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Enable,
    packet_injector_if.master   bus,
    output logic [15:0]         SentCount,
    output logic                Done
);
    localparam logic [2:0] DimMask = 3'(dim - 1);

    inj_state_e            r_state;
    inj_state_e            w_next;
    logic [dataWidth-1:0]  r_packet;
    logic [dataWidth-1:0]  w_pkt;
    logic [9:0]            r_pid;
    logic [15:0]           r_sent;
    logic                  r_done;
    logic [7:0]            r_gap;
    logic [15:0]           w_lfsr;
    logic [10:0]           w_lfsr_unused;
    node_id_t              w_dest;
    logic                  w_last;
    logic                  w_adv;
    logic                  w_grant;
    logic                  w_gap_end;

    noc_lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_adv   (w_adv),
        .o_state (w_lfsr)
    );
    assign w_lfsr_unused = {w_lfsr[15:5], w_lfsr[2]};

    assign w_dest = (TrafficMode != 0)
                  ? rand_dest({w_lfsr[4:3], w_lfsr[1:0]}, ModuleID, DimMask)
                  : DestID;

    always_comb begin
        w_pkt                 = '0;
        w_pkt[DEST_HI:DEST_LO] = w_dest;
        w_pkt[PID_HI:PID_LO]   = r_pid;
        w_pkt[SRC_HI:SRC_LO]   = ModuleID;
    end

    assign w_last    = (NumPackets != 0) && (r_sent == 16'(NumPackets));
    assign w_gap_end = (r_state == ST_GAP) && (r_gap == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (Enable && !r_done) w_next = ST_LOAD;
            ST_LOAD: if (!bus.DnStrFull)    w_next = ST_REQ;
            // Full is ignored here: a raised request is only withdrawn by a grant.
            ST_REQ:  if (bus.GntDnStr)      w_next = ST_GAP;
            ST_GAP: begin
                if (r_gap == 8'd0) begin
                    if (w_last)      w_next = ST_IDLE;
                    else if (Enable) w_next = ST_LOAD;
                    else             w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ReqDnStr = (r_state == ST_REQ);
        // LFSR steps once per packet, on the way out of LOAD.
        w_adv        = (r_state == ST_LOAD) && !bus.DnStrFull;
        w_grant      = (r_state == ST_REQ) && bus.GntDnStr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_packet <= '0;
            r_pid    <= '0;
            r_sent   <= '0;
            r_done   <= 1'b0;
            r_gap    <= '0;
        end else begin
            if (r_state == ST_LOAD) r_packet <= w_pkt;
            if (w_grant) begin
                r_pid  <= r_pid + 10'd1;
                r_sent <= r_sent + 16'd1;
                r_gap  <= 8'(InjectGap);
            end else if (r_state == ST_GAP && r_gap != 8'd0) begin
                r_gap <= r_gap - 8'd1;
            end
            if (w_gap_end && w_last) r_done <= 1'b1;
        end
    end

    assign bus.PacketOut = r_packet;
    assign SentCount     = r_sent;
    assign Done          = r_done;
endmodule
